// File: rtl/vga_bus_arbiter_if.sv
// Bundle of request, completion, pixel and status signals between the drawing
// clients, the arbiter and the VGA adapter.
interface vga_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    done_in;
  logic [8*NUM_REQ-1:0]  req_x_in;
  logic [8*NUM_REQ-1:0]  req_y_in;
  logic [24*NUM_REQ-1:0] req_rgb_in;
  logic [NUM_REQ-1:0]    req_plot_in;
  logic [NUM_REQ-1:0]    start;
  logic [NUM_REQ-1:0]    grant;
  logic [7:0]            vga_x;
  logic [7:0]            vga_y;
  logic [23:0]           vga_colour;
  logic                  vga_plot;
  logic                  busy;
  logic                  timeout_err;

  // Arbiter side
  modport master (
    input  req, done_in, req_x_in, req_y_in, req_rgb_in, req_plot_in,
    output start, grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
  );

  // Client / adapter side
  modport slave (
    output req, done_in, req_x_in, req_y_in, req_rgb_in, req_plot_in,
    input  start, grant, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err
  );
endinterface

// File: rtl/vga_bus_arbiter.sv
// Round-robin owner of the single VGA pixel port: grants one drawing client at a
// time, pulses its start, and forwards only its pixel bus through a registered mux.
module vga_bus_arbiter #(
  parameter int unsigned       NUM_REQ        = 4,
  parameter int unsigned       TO_W           = 18,
  parameter logic [TO_W-1:0]   TIMEOUT_CYCLES = 18'd70000
) (
  input  logic                  clk,
  input  logic                  resetn,
  vga_bus_arbiter_if.master     bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] start_q, start_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic [7:0]         vga_x_q, vga_x_d;
  logic [7:0]         vga_y_q, vga_y_d;
  logic [23:0]        vga_col_q, vga_col_d;
  logic               plot_q, plot_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   g_idx;

  // Index arithmetic modulo NUM_REQ; offsets stay below NUM_REQ so one subtract suffices
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // First requester scanning circularly from the priority pointer
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && bus.req[wrap_inc(ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_inc(ptr_q, k);
      end
    end
  end

  // Encode the one-hot grant back to the owner index
  always_comb begin
    g_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) g_idx = IDX_W'(k);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    start_d   = '0;
    ptr_d     = ptr_q;
    wd_d      = '0;
    terr_d    = terr_q;
    vga_x_d   = vga_x_q;
    vga_y_d   = vga_y_q;
    vga_col_d = vga_col_q;
    plot_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          start_d = NUM_REQ'(1) << pick_idx;
          state_d = START;
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Completion wins over a simultaneous watchdog expiry
        if (bus.done_in[g_idx]) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = wrap_inc(g_idx, 32'd1);
        end else if (wd_q == (TIMEOUT_CYCLES - TO_W'(1))) begin
          terr_d  = 1'b1;
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = wrap_inc(g_idx, 32'd1);
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase

    // Only the owner's pixel bus reaches the adapter; coordinates hold otherwise
    if (state_q == START || state_q == WAIT) begin
      vga_x_d   = bus.req_x_in[32'(g_idx)*8 +: 8];
      vga_y_d   = bus.req_y_in[32'(g_idx)*8 +: 8];
      vga_col_d = bus.req_rgb_in[32'(g_idx)*24 +: 24];
      plot_d    = bus.req_plot_in[g_idx];
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      start_q   <= '0;
      ptr_q     <= '0;
      wd_q      <= '0;
      vga_x_q   <= '0;
      vga_y_q   <= '0;
      vga_col_q <= '0;
      plot_q    <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
      ptr_q     <= ptr_d;
      wd_q      <= wd_d;
      vga_x_q   <= vga_x_d;
      vga_y_q   <= vga_y_d;
      vga_col_q <= vga_col_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign bus.start       = start_q;
  assign bus.grant       = grant_q;
  assign bus.vga_x       = vga_x_q;
  assign bus.vga_y       = vga_y_q;
  assign bus.vga_colour  = vga_col_q;
  assign bus.vga_plot    = plot_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: doc/vga_bus_arbiter.md
Name: vga_bus_arbiter

Overview:
- Shares the single VGA adapter pixel port among NUM_REQ drawing clients: screen refresh, tile drawer, sprite drawers.
- Round-robin arbitration. Issues a one-cycle start pulse to the granted client's enable, holds the grant until that client pulses done, and muxes only the granted client's pixel bus to the adapter.
- Replaces tri-state bus sharing with a registered mux.
- Sits between the game FSM's drawing clients and the VGA adapter.

Parameters:
- NUM_REQ, 4, number of drawing clients (2..8).
- TO_W, 18, width of the watchdog counter.
- TIMEOUT_CYCLES, 18'd70000, maximum WAIT cycles before a grant is forcibly revoked. Must exceed a full 256x256 refresh plus margin.

Ports:
- clk  input  1  system clock, all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- req  input  NUM_REQ  level request per client; bit i = client i
- done_in  input  NUM_REQ  client completion pulse; bit i = client i
- req_x_in  input  8*NUM_REQ  client i x at [8i+7:8i]
- req_y_in  input  8*NUM_REQ  client i y at [8i+7:8i]
- req_rgb_in  input  24*NUM_REQ  client i colour at [24i+23:24i]
- req_plot_in  input  NUM_REQ  client i pixel write strobe
- start  output  NUM_REQ  one-cycle start pulse to granted client
- grant  output  NUM_REQ  one-hot current owner; all zero when free
- vga_x  output  8  to adapter
- vga_y  output  8  to adapter
- vga_colour  output  24  to adapter
- vga_plot  output  1  to adapter write enable
- busy  output  1  high whenever state != IDLE
- timeout_err  output  1  sticky; set on watchdog expiry

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; grant, start, vga_x, vga_y, vga_colour, vga_plot, busy, timeout_err = 0; priority pointer ptr=0; watchdog=0. Reset mid-WAIT drops the grant immediately; the client is not notified.
- FSM states and transitions:
  - IDLE: if req != 0, select the first set bit scanning circularly from ptr (ptr, ptr+1, ..., wrap). Register grant to that one-hot and go to START. If req == 0, stay.
  - START (1 cycle): start = grant; go to WAIT. done_in is ignored in this cycle.
  - WAIT: start = 0; watchdog increments each cycle.
    - If done_in[g]=1 (g = granted index), go to RELEASE with ptr <= (g+1) mod NUM_REQ.
    - Else if watchdog == TIMEOUT_CYCLES-1, set timeout_err=1, go to RELEASE, ptr <= (g+1) mod NUM_REQ.
    - done_in and timeout in the same cycle: treat as done; timeout_err is not set.
  - RELEASE (1 cycle): grant=0, watchdog=0, go to IDLE.
- Latency:
  - req first seen high in IDLE at edge n: grant and start visible after edge n+1.
  - Back-to-back grants are separated by at least 2 cycles with grant=0 (RELEASE, then IDLE).
- Request rules:
  - Dropping req during START/WAIT does not revoke the grant; only done or timeout ends it.
  - done_in from non-granted clients is ignored in all states.
- Pixel mux, registered with 1-cycle latency:
  - In START/WAIT: vga_x, vga_y, vga_colour <= client g slices; vga_plot <= req_plot_in[g].
  - In all other states: vga_plot <= 0 and x/y/colour hold their values.
  - A plot asserted in the same cycle as done_in[g] is still forwarded.
  - Plots from non-granted clients never reach the adapter.
- Fairness: after client i is served, every other requesting client is served before i again.
- Ties from IDLE resolve by circular order from ptr.
- ptr arithmetic wraps mod NUM_REQ; NUM_REQ need not be a power of two.
- timeout_err clears only on reset.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles, req=0 -> all outputs 0, busy=0 for 10 cycles.
- Single client: req=4'b0010 at cycle 0, then done_in[1] pulse 5 cycles after start.
  - grant=4'b0010 and start=4'b0010 (one cycle) after the next edge.
  - busy stays high through RELEASE; grant=0 for exactly 1 cycle before IDLE.
- Round robin: req=4'b1111 held, each client pulses done 3 cycles after its start -> grant order 0001, 0010, 0100, 1000, 0001, with each grant gap exactly 2 cycles.
- Mux isolation: client 2 granted, client 0 drives plot=1, x=8'h11; client 2 drives plot=1, x=8'h22, y=8'h33, rgb=24'hFFFFFF -> one cycle later vga_x=8'h22, vga_y=8'h33, vga_colour=24'hFFFFFF, vga_plot=1; 8'h11 never appears.
- Watchdog: TIMEOUT_CYCLES=16, client 3 granted and never sends done -> grant drops after 16 WAIT cycles, timeout_err=1 and stays 1, next grant goes to client 0 if it is requesting.
- Reset mid-operation: resetn=0 during WAIT with req=4'b0101 -> next cycle grant=0, vga_plot=0, ptr=0; after release the first grant is 4'b0001.
